// File: rtl/carrier_loop_pkg.sv
// Shared definitions for the DPSK carrier-recovery loop controller:
// state encoding and default loop-gain shift values.
package carrier_loop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2
    } loop_state_e;

    localparam int PD_W_DEF = 28;

    localparam logic [4:0] C1_ACQ_DEF = 5'd8;
    localparam logic [4:0] C2_ACQ_DEF = 5'd3;
    localparam logic [4:0] C1_TRK_DEF = 5'd10;
    localparam logic [4:0] C2_TRK_DEF = 5'd5;

endpackage

// File: rtl/loop_lock_det.sv
// Lock detector: saturating |pd|, threshold test and the good/bad run
// counters, updated once per loop update on the integrator strobe.
module loop_lock_det
    import carrier_loop_pkg::*;
#(
    parameter int PD_W       = PD_W_DEF,
    parameter int LOCK_TH    = 1048576,
    parameter int LOCK_CNT   = 64,
    parameter int UNLOCK_CNT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample,
    input  logic                   clr,
    input  logic signed [PD_W-1:0] pd,
    output logic                   lock_hit,
    output logic                   unlock_hit
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam int BC_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [GC_W-1:0] GOOD_MAX  = GC_W'(LOCK_CNT);
    localparam logic [GC_W-1:0] GOOD_LAST = GC_W'(LOCK_CNT - 1);
    localparam logic [BC_W-1:0] BAD_MAX   = BC_W'(UNLOCK_CNT);
    localparam logic [BC_W-1:0] BAD_LAST  = BC_W'(UNLOCK_CNT - 1);

    localparam logic [PD_W-1:0]        TH     = PD_W'(LOCK_TH);
    localparam logic signed [PD_W-1:0] PD_MIN = {1'b1, {(PD_W-1){1'b0}}};
    localparam logic [PD_W-1:0]        MAG_MAX = {1'b0, {(PD_W-1){1'b1}}};

    // The most negative code has no positive twin; clamp it to full scale.
    function automatic logic [PD_W-1:0] abs_sat(input logic signed [PD_W-1:0] x);
        logic signed [PD_W-1:0] neg;
        neg = -x;
        if (x == PD_MIN) begin
            return MAG_MAX;
        end
        return x[PD_W-1] ? $unsigned(neg) : $unsigned(x);
    endfunction

    logic [PD_W-1:0] pd_mag;
    logic            good;
    logic [GC_W-1:0] good_cnt_q, good_cnt_d;
    logic [BC_W-1:0] bad_cnt_q, bad_cnt_d;

    assign pd_mag = abs_sat(pd);
    assign good   = (pd_mag < TH);

    assign lock_hit   = sample &&  good && (good_cnt_q == GOOD_LAST);
    assign unlock_hit = sample && !good && (bad_cnt_q == BAD_LAST);

    always_comb begin
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (clr) begin
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (sample) begin
            if (good) begin
                bad_cnt_d = '0;
                if (good_cnt_q != GOOD_MAX) begin
                    good_cnt_d = good_cnt_q + GC_W'(1);
                end
            end else begin
                good_cnt_d = '0;
                if (bad_cnt_q != BAD_MAX) begin
                    bad_cnt_d = bad_cnt_q + BC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

endmodule

// File: rtl/carrier_loop_ctrl.sv
// Carrier-recovery loop controller: update strobes, gain scheduling,
// IDLE/ACQ/TRACK sequencing with acquisition timeout.
module carrier_loop_ctrl
    import carrier_loop_pkg::*;
#(
    parameter int         PD_W        = PD_W_DEF,
    parameter int         UPD_PERIOD  = 16,
    parameter int         LOCK_TH     = 1048576,
    parameter int         LOCK_CNT    = 64,
    parameter int         UNLOCK_CNT  = 16,
    parameter int         ACQ_TIMEOUT = 4096,
    parameter logic [4:0] C1_ACQ      = C1_ACQ_DEF,
    parameter logic [4:0] C2_ACQ      = C2_ACQ_DEF,
    parameter logic [4:0] C1_TRK      = C1_TRK_DEF,
    parameter logic [4:0] C2_TRK      = C2_TRK_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   freeze,
    input  logic signed [PD_W-1:0] pd,
    output logic                   acc_en,
    output logic                   out_en,
    output logic                   acc_clr,
    output logic [4:0]             c1_shift,
    output logic [4:0]             c2_shift,
    output logic                   locked,
    output logic [1:0]             state,
    output logic                   timeout
);

    localparam int PH_W = $clog2(UPD_PERIOD);
    localparam int UC_W = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [PH_W-1:0] PH_ACC   = PH_W'(UPD_PERIOD - 4);
    localparam logic [PH_W-1:0] PH_OUT   = PH_W'(UPD_PERIOD - 3);
    localparam logic [UC_W-1:0] UPD_LAST = UC_W'(ACQ_TIMEOUT - 1);

    loop_state_e     state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [UC_W-1:0] upd_cnt_q, upd_cnt_d;
    logic            acc_en_q, acc_en_d;
    logic            out_en_q, out_en_d;
    logic            acc_clr_q, acc_clr_d;
    logic            locked_q, locked_d;
    logic            timeout_q, timeout_d;
    logic [4:0]      c1_q, c1_d;
    logic [4:0]      c2_q, c2_d;
    logic            det_clr;
    logic            lock_hit;
    logic            unlock_hit;

    // A strobe already on the output is treated as consumed by the loop
    // filter, so the detector always sees it, even in a freeze cycle.
    loop_lock_det #(
        .PD_W       (PD_W),
        .LOCK_TH    (LOCK_TH),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock_det (
        .clk        (clk),
        .rst        (rst),
        .sample     (acc_en_q),
        .clr        (det_clr),
        .pd         (pd),
        .lock_hit   (lock_hit),
        .unlock_hit (unlock_hit)
    );

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        upd_cnt_d = upd_cnt_q;
        locked_d  = locked_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        timeout_d = 1'b0;
        acc_en_d  = 1'b0;
        out_en_d  = 1'b0;
        det_clr   = 1'b0;

        if (!en) begin
            state_d   = ST_IDLE;
            phase_d   = '0;
            upd_cnt_d = '0;
            locked_d  = 1'b0;
            det_clr   = 1'b1;
            c1_d      = C1_ACQ;
            c2_d      = C2_ACQ;
        end else if (state_q == ST_IDLE) begin
            if (!freeze) begin
                state_d = ST_ACQ;
                phase_d = '0;
            end
        end else begin
            case (state_q)
                ST_ACQ: begin
                    if (acc_en_q) begin
                        if (lock_hit) begin
                            state_d   = ST_TRACK;
                            locked_d  = 1'b1;
                            det_clr   = 1'b1;
                            upd_cnt_d = '0;
                        end else if (upd_cnt_q == UPD_LAST) begin
                            timeout_d = 1'b1;
                            det_clr   = 1'b1;
                            upd_cnt_d = '0;
                        end else begin
                            upd_cnt_d = upd_cnt_q + UC_W'(1);
                        end
                    end
                end
                ST_TRACK: begin
                    if (acc_en_q && unlock_hit) begin
                        state_d   = ST_ACQ;
                        locked_d  = 1'b0;
                        det_clr   = 1'b1;
                        upd_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (timeout_d) begin
                phase_d = '0;
            end else if (!freeze) begin
                phase_d = phase_q + PH_W'(1);
            end
        end

        // Gains only reload at phase 0 so an acc_en/out_en pair shares one gain set.
        if (state_d != ST_IDLE && !freeze) begin
            acc_en_d = (phase_d == PH_ACC);
            out_en_d = (phase_d == PH_OUT);
            if (phase_d == '0) begin
                c1_d = (state_d == ST_TRACK) ? C1_TRK : C1_ACQ;
                c2_d = (state_d == ST_TRACK) ? C2_TRK : C2_ACQ;
            end
        end

        acc_clr_d = timeout_d || (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            upd_cnt_q <= '0;
            acc_en_q  <= 1'b0;
            out_en_q  <= 1'b0;
            acc_clr_q <= 1'b1;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            c1_q      <= C1_ACQ;
            c2_q      <= C2_ACQ;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            upd_cnt_q <= upd_cnt_d;
            acc_en_q  <= acc_en_d;
            out_en_q  <= out_en_d;
            acc_clr_q <= acc_clr_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
        end
    end

    assign acc_en   = acc_en_q;
    assign out_en   = out_en_q;
    assign acc_clr  = acc_clr_q;
    assign c1_shift = c1_q;
    assign c2_shift = c2_q;
    assign locked   = locked_q;
    assign state    = state_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_carrier_loop_ctrl.sv
// Bench for carrier_loop_ctrl: directed scenarios plus random traffic, all
// compared against a per-clock behavioural model of the loop controller.
module tb_carrier_loop_ctrl;

    localparam int PD_W       = 28;
    localparam int UPD        = 16;
    localparam int LOCK_TH    = 1048576;
    localparam int LOCK_CNT   = 64;
    localparam int UNLOCK_CNT = 16;
    localparam int ACQ_TO     = 64;
    localparam int MAG_MAX    = 134217727;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   en = 1'b0;
    logic                   freeze = 1'b0;
    logic signed [PD_W-1:0] pd = '0;
    logic                   acc_en, out_en, acc_clr, locked, timeout;
    logic [4:0]             c1_shift, c2_shift;
    logic [1:0]             state;

    int checks = 0;
    int errors = 0;

    carrier_loop_ctrl #(
        .ACQ_TIMEOUT (ACQ_TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .freeze   (freeze),
        .pd       (pd),
        .acc_en   (acc_en),
        .out_en   (out_en),
        .acc_clr  (acc_clr),
        .c1_shift (c1_shift),
        .c2_shift (c2_shift),
        .locked   (locked),
        .state    (state),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0/1/2 = idle/acquire/track, runs counted unbounded.
    int m_mode, m_ph, m_good_run, m_bad_run, m_updates, m_c1, m_c2;
    bit m_locked, m_acc, m_out, m_clr, m_to;

    int diffs = 0;
    logic [16:0] last_act, last_exp;
    int n_acc, n_out, n_to, n_clr;

    function automatic void model_step();
        bit     strobe;
        bit     restart;
        longint mag;
        if (!rst) begin
            m_mode = 0; m_ph = 0; m_good_run = 0; m_bad_run = 0; m_updates = 0;
            m_locked = 0; m_acc = 0; m_out = 0; m_clr = 1; m_to = 0;
            m_c1 = 8; m_c2 = 3;
            return;
        end
        strobe  = m_acc;
        restart = 0;
        m_acc = 0; m_out = 0; m_to = 0;
        if (!en) begin
            m_mode = 0; m_ph = 0; m_good_run = 0; m_bad_run = 0; m_updates = 0;
            m_locked = 0; m_clr = 1; m_c1 = 8; m_c2 = 3;
            return;
        end
        if (m_mode == 0) begin
            if (!freeze) begin
                m_mode = 1; m_ph = 0; m_clr = 0; m_c1 = 8; m_c2 = 3;
            end else begin
                m_clr = 1;
            end
            return;
        end
        if (strobe) begin
            mag = longint'(pd);
            if (mag < 0) mag = -mag;
            if (mag > MAG_MAX) mag = MAG_MAX;
            if (mag < LOCK_TH) begin
                m_good_run++; m_bad_run = 0;
            end else begin
                m_bad_run++; m_good_run = 0;
            end
            if (m_mode == 1) begin
                if (m_good_run >= LOCK_CNT) begin
                    m_mode = 2; m_locked = 1;
                    m_good_run = 0; m_bad_run = 0; m_updates = 0;
                end else begin
                    m_updates++;
                    if (m_updates >= ACQ_TO) begin
                        m_to = 1; restart = 1;
                        m_good_run = 0; m_bad_run = 0; m_updates = 0;
                    end
                end
            end else if (m_bad_run >= UNLOCK_CNT) begin
                m_mode = 1; m_locked = 0;
                m_good_run = 0; m_bad_run = 0; m_updates = 0;
            end
        end
        m_clr = restart;
        if (restart) m_ph = 0;
        else if (!freeze) m_ph = (m_ph + 1) % UPD;
        if (!freeze) begin
            m_acc = (m_ph == UPD - 4);
            m_out = (m_ph == UPD - 3);
            if (m_ph == 0) begin
                m_c1 = (m_mode == 2) ? 10 : 8;
                m_c2 = (m_mode == 2) ? 5 : 3;
            end
        end
    endfunction

    function automatic logic [16:0] exp_vec();
        return {m_acc, m_out, m_clr, 5'(m_c1), 5'(m_c2), m_locked, 2'(m_mode), m_to};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {acc_en, out_en, acc_clr, c1_shift, c2_shift, locked, state, timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (acc_en) n_acc++;
        if (out_en) n_out++;
        if (timeout) n_to++;
        if (acc_clr && state != 2'd0) n_clr++;
        if (dut_vec() !== exp_vec()) begin
            diffs++;
            last_act = dut_vec();
            last_exp = exp_vec();
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Holds pd for n update samples; returns with the last sample consumed.
    task automatic run_samples(input int n, input logic signed [PD_W-1:0] val, output bit ok);
        int cnt = 0;
        int guard = 0;
        pd = val;
        while (cnt < n && guard < n * UPD + 40) begin
            tick();
            guard++;
            if (m_acc) cnt++;
        end
        ok = (cnt == n);
        if (ok) tick();
    endtask

    function automatic logic signed [PD_W-1:0] rand_pd(input bit good);
        int mag;
        if (good) begin
            mag = int'($urandom_range(LOCK_TH - 1, 0));
        end else begin
            if ($urandom_range(7, 0) == 0) return {1'b1, {(PD_W-1){1'b0}}};
            mag = int'($urandom_range(MAG_MAX, LOCK_TH));
        end
        if ($urandom_range(1, 0) == 1) mag = -mag;
        return PD_W'(mag);
    endfunction

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; freeze = 1'b0; pd = '0;
        run_cycles(3);
        rst = 1'b1;
        diffs = 0; n_acc = 0; n_out = 0; n_to = 0; n_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; freeze = 1'b0; pd = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({state, acc_clr, c1_shift, c2_shift, acc_en, out_en, locked, timeout}
                !== {2'd0, 1'b1, 5'd8, 5'd3, 4'b0000}) begin
                errors++;
                $display("FAIL reset_state: got %b want %b",
                         {state, acc_clr, c1_shift, c2_shift, acc_en, out_en, locked, timeout},
                         {2'd0, 1'b1, 5'd8, 5'd3, 4'b0000});
            end
        end
        rst = 1'b1;
        diffs = 0; n_acc = 0; n_out = 0;
        run_cycles(100);
        checks++;
        if (n_acc + n_out !== 0) begin
            errors++;
            $display("FAIL idle_strobes: got %0d strobes want 0", n_acc + n_out);
        end
        checks++;
        if ({state, acc_clr} !== 3'b001) begin
            errors++;
            $display("FAIL idle_state: got state=%0d acc_clr=%b want 0/1", state, acc_clr);
        end
        checks++;
        if (diffs !== 0) begin
            errors++;
            $display("FAIL idle_model: %0d cycles differ, last got %h want %h", diffs, last_act, last_exp);
        end
    endtask

    task automatic test_strobe_timing();
        int cyc;
        int gap;
        do_reset();
        en = 1'b1;
        tick();
        checks++;
        if ({state, acc_clr} !== 3'b010) begin
            errors++;
            $display("FAIL acq_entry: got state=%0d acc_clr=%b want 1/0", state, acc_clr);
        end
        cyc = 1;
        while (!acc_en && cyc < 40) begin tick(); cyc++; end
        checks++;
        if (cyc !== 13) begin
            errors++;
            $display("FAIL first_acc_en: got clock %0d want 13", cyc);
        end
        tick();
        checks++;
        if ({acc_en, out_en} !== 2'b01) begin
            errors++;
            $display("FAIL out_en_follow: got acc/out=%b want 01", {acc_en, out_en});
        end
        gap = 1;
        while (!acc_en && gap < 40) begin tick(); gap++; end
        checks++;
        if (gap !== UPD) begin
            errors++;
            $display("FAIL acc_period: got %0d want %0d", gap, UPD);
        end
        // Reset during an active strobe cycle.
        rst = 1'b0;
        tick();
        checks++;
        if ({acc_en, out_en, state, acc_clr} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_over_strobe: got %b want 00001", {acc_en, out_en, state, acc_clr});
        end
        rst = 1'b1;
        checks++;
        if (diffs !== 0) begin
            errors++;
            $display("FAIL strobe_model: %0d cycles differ, last got %h want %h", diffs, last_act, last_exp);
        end
    endtask

    task automatic test_lock();
        bit ok;
        bit all_ok = 1;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < LOCK_CNT - 1; i++) begin
            run_samples(1, rand_pd(1'b1), ok);
            all_ok &= ok;
        end
        checks++;
        if ({state, locked} !== 3'b010 || !all_ok) begin
            errors++;
            $display("FAIL pre_lock: got state=%0d locked=%b ok=%b want 1/0/1", state, locked, all_ok);
        end
        run_samples(1, PD_W'(-(LOCK_TH - 1)), ok);
        checks++;
        if ({state, locked, c1_shift} !== {2'd2, 1'b1, 5'd8} || !ok) begin
            errors++;
            $display("FAIL lock: got state=%0d locked=%b c1=%0d want 2/1/8", state, locked, c1_shift);
        end
        run_cycles(3);
        checks++;
        if ({c1_shift, c2_shift} !== {5'd10, 5'd5}) begin
            errors++;
            $display("FAIL track_gains: got %0d/%0d want 10/5", c1_shift, c2_shift);
        end
        checks++;
        if (diffs !== 0) begin
            errors++;
            $display("FAIL lock_model: %0d cycles differ, last got %h want %h", diffs, last_act, last_exp);
        end
    endtask

    task automatic test_unlock();
        bit ok;
        bit all_ok = 1;
        diffs = 0;
        for (int i = 0; i < UNLOCK_CNT - 1; i++) begin
            run_samples(1, PD_W'(2097152), ok);
            all_ok &= ok;
        end
        run_samples(1, '0, ok);
        all_ok &= ok;
        checks++;
        if ({state, locked} !== 3'b101 || !all_ok) begin
            errors++;
            $display("FAIL unlock_hold1: got state=%0d locked=%b ok=%b want 2/1/1", state, locked, all_ok);
        end
        for (int i = 0; i < UNLOCK_CNT - 1; i++) begin
            run_samples(1, PD_W'(2097152), ok);
            all_ok &= ok;
        end
        checks++;
        if ({state, locked} !== 3'b101 || !all_ok) begin
            errors++;
            $display("FAIL unlock_hold2: got state=%0d locked=%b want 2/1", state, locked);
        end
        run_samples(1, PD_W'(LOCK_TH), ok);
        checks++;
        if ({state, locked} !== 3'b010 || !ok) begin
            errors++;
            $display("FAIL unlock: got state=%0d locked=%b want 1/0", state, locked);
        end
        run_cycles(3);
        checks++;
        if ({c1_shift, c2_shift} !== {5'd8, 5'd3}) begin
            errors++;
            $display("FAIL acq_gains: got %0d/%0d want 8/3", c1_shift, c2_shift);
        end
        checks++;
        if (diffs !== 0) begin
            errors++;
            $display("FAIL unlock_model: %0d cycles differ, last got %h want %h", diffs, last_act, last_exp);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit all_ok = 1;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < ACQ_TO - 1; i++) begin
            run_samples(1, (i % 2 == 0) ? {1'b1, {(PD_W-1){1'b0}}} : rand_pd(1'b0), ok);
            all_ok &= ok;
        end
        checks++;
        if (n_to !== 0 || !all_ok) begin
            errors++;
            $display("FAIL early_timeout: got %0d pulses want 0", n_to);
        end
        run_samples(1, {1'b1, {(PD_W-1){1'b0}}}, ok);
        checks++;
        if ({timeout, acc_clr, state} !== 4'b1101 || !ok) begin
            errors++;
            $display("FAIL timeout_pulse: got to/clr/state=%b want 1101", {timeout, acc_clr, state});
        end
        tick();
        checks++;
        if ({timeout, acc_clr, state} !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_end: got to/clr/state=%b want 0001", {timeout, acc_clr, state});
        end
        for (int i = 0; i < ACQ_TO; i++) begin
            run_samples(1, rand_pd(1'b0), ok);
            all_ok &= ok;
        end
        checks++;
        if (n_to !== 2 || n_clr !== 2 || !all_ok) begin
            errors++;
            $display("FAIL timeout_count: got to=%0d clr=%0d want 2/2", n_to, n_clr);
        end
        checks++;
        if (diffs !== 0) begin
            errors++;
            $display("FAIL timeout_model: %0d cycles differ, last got %h want %h", diffs, last_act, last_exp);
        end
    endtask

    task automatic test_freeze_disable();
        bit ok;
        bit all_ok = 1;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            run_samples(1, rand_pd(1'b1), ok);
            all_ok &= ok;
        end
        run_cycles(2);
        freeze = 1'b1;
        n_acc = 0; n_out = 0;
        run_cycles(40);
        checks++;
        if (n_acc + n_out !== 0 || state !== 2'd1) begin
            errors++;
            $display("FAIL freeze_hold: got strobes=%0d state=%0d want 0/1", n_acc + n_out, state);
        end
        freeze = 1'b0;
        for (int i = 0; i < 33; i++) begin
            run_samples(1, rand_pd(1'b1), ok);
            all_ok &= ok;
        end
        checks++;
        if (state !== 2'd1 || !all_ok) begin
            errors++;
            $display("FAIL freeze_resume: got state=%0d want 1", state);
        end
        run_samples(1, rand_pd(1'b1), ok);
        checks++;
        if ({state, locked} !== 3'b101 || !ok) begin
            errors++;
            $display("FAIL freeze_lock: got state=%0d locked=%b want 2/1", state, locked);
        end
        freeze = 1'b1;
        en = 1'b0;
        tick();
        checks++;
        if ({state, locked, acc_clr, c1_shift, c2_shift} !== {2'd0, 1'b0, 1'b1, 5'd8, 5'd3}) begin
            errors++;
            $display("FAIL disable: got state=%0d locked=%b clr=%b c1=%0d c2=%0d want 0/0/1/8/3",
                     state, locked, acc_clr, c1_shift, c2_shift);
        end
        freeze = 1'b0;
        checks++;
        if (diffs !== 0) begin
            errors++;
            $display("FAIL freeze_model: %0d cycles differ, last got %h want %h", diffs, last_act, last_exp);
        end
    endtask

    task automatic test_random();
        bit mostly_good = 1;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 256 == 0) mostly_good = ($urandom_range(3, 0) != 0);
            pd = rand_pd(mostly_good ? ($urandom_range(49, 0) != 0) : ($urandom_range(3, 0) == 0));
            if ($urandom_range(59, 0) == 0) freeze = ~freeze;
            if ($urandom_range(299, 0) == 0) en = ~en;
            rst = ($urandom_range(799, 0) != 0);
            tick();
        end
        rst = 1'b1;
        checks++;
        if (diffs !== 0) begin
            errors++;
            $display("FAIL random_model: %0d cycles differ, last got %h want %h", diffs, last_act, last_exp);
        end
    endtask

    initial begin
        test_reset();
        test_strobe_timing();
        test_lock();
        test_unlock();
        test_timeout();
        test_freeze_disable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/carrier_loop_ctrl.md
Name: carrier_loop_ctrl

Overview:
Controller for the DPSK carrier-recovery loop (phase detector plus PI loop filter, 32 MHz).
- Generates the 1-in-UPD_PERIOD update strobes for the loop-filter integrator and output register.
- Schedules the loop gains: wide in acquisition, narrow in tracking.
- Runs a lock detector on the phase-detector output, with acquisition timeout and restart.
- Sits between the phase detector/loop filter and the NCO frequency-word path.

Parameters:
PD_W, 28, phase-detector output width (signed)
UPD_PERIOD, 16, clocks per loop update; power of two, minimum 4
LOCK_TH, 1048576, |pd| strictly below this value is a "good" sample
LOCK_CNT, 64, consecutive good samples to declare lock
UNLOCK_CNT, 16, consecutive bad samples to declare loss of lock
ACQ_TIMEOUT, 4096, updates in ACQ without lock before restart
C1_ACQ/C2_ACQ, 8/3, integrator/proportional right-shifts in ACQ
C1_TRK/C2_TRK, 10/5, integrator/proportional right-shifts in TRACK

Ports:
clk  in  1  system clock, 32 MHz
rst  in  1  synchronous, active-low reset
en  in  1  loop enable; low forces IDLE from any state
freeze  in  1  hold loop: strobes suppressed, all counters and state held
pd  in  PD_W  signed phase error, valid every clock
acc_en  out  1  one-clock strobe: integrator accumulates
out_en  out  1  one-clock strobe: loop-filter output register loads
acc_clr  out  1  integrator/output clear
c1_shift  out  5  integrator gain shift
c2_shift  out  5  proportional gain shift
locked  out  1  lock indication
state  out  2  0=IDLE, 1=ACQ, 2=TRACK
timeout  out  1  one-clock pulse on acquisition timeout

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE; phase counter, good/bad counters and update counter all 0; acc_en=out_en=locked=timeout=0; acc_clr=1; c1_shift=C1_ACQ; c2_shift=C2_ACQ.
- IDLE:
  - acc_clr=1; no strobes.
  - en=1 moves to ACQ next cycle. The phase counter starts at 0 in the first ACQ cycle. acc_clr drops to 0 in that same cycle.
- Phase counter: counts 0..UPD_PERIOD-1 and wraps; runs in ACQ and TRACK only.
  - acc_en=1 when phase==UPD_PERIOD-4.
  - out_en=1 when phase==UPD_PERIOD-3.
  - Strobes are registered outputs and never overlap.
- Gain shifts:
  - Registered; update only when phase==0, so a gain change never splits an acc_en/out_en pair.
  - ACQ uses C1_ACQ/C2_ACQ; TRACK uses C1_TRK/C2_TRK.
- Lock detector:
  - Samples pd only in the acc_en cycle.
  - |pd| saturates: -2^(PD_W-1) maps to 2^(PD_W-1)-1.
  - good = |pd| < LOCK_TH.
  - good: increment good_cnt (saturate at LOCK_CNT), clear bad_cnt. bad: increment bad_cnt (saturate), clear good_cnt.
- ACQ to TRACK: a good sample brings good_cnt to LOCK_CNT. Transition at that clock edge; locked=1 from the next cycle; counters cleared.
- TRACK to ACQ: bad_cnt reaches UNLOCK_CNT. locked=0 from the next cycle; counters and update counter cleared. The integrator is not cleared.
- ACQ timeout:
  - The update counter increments on each acc_en in ACQ.
  - When it reaches ACQ_TIMEOUT with no lock: timeout=1 and acc_clr=1 for one cycle, phase and all counters reset to 0, state stays ACQ.
  - If lock and timeout occur on the same sample, lock wins and there is no timeout pulse.
- freeze=1: no acc_en/out_en. Phase, counters, state, gains and locked all hold. Resumes exactly where it stopped.
- en=0 overrides freeze and lock: next cycle state=IDLE, locked=0, acc_clr=1, gains return to ACQ values.
- Reset overrides everything, including an active strobe cycle.

Decomposition:
- Shared package carrier_loop_pkg holds:
  - the state encoding (IDLE/ACQ/TRACK)
  - default shift constants C1_ACQ, C2_ACQ, C1_TRK, C2_TRK
  - the PD_W default
- One sub-module, loop_lock_det:
  - contents: |pd| saturation, threshold compare, and the good/bad run counters
  - interface: inputs sample strobe, counter clear and pd; outputs lock_hit and unlock_hit
- The FSM, phase counter and gain registers stay in the top module.

Test Plan:
- Reset/idle: rst=0 for 3 clks, en=0 -> state=0, acc_clr=1, c1_shift=8, c2_shift=3, no strobes over 100 clks.
- Strobe timing: en=1, pd=0 -> acc_en at phase 12, out_en at phase 13, every 16 clks; first acc_en on clock 13 after entering ACQ.
- Lock: pd=1000 constant -> state=2 and locked=1 after the 64th acc_en; shifts become 10/5 at the next phase 0.
- Unlock: in TRACK, 15 samples of pd=2^21 then one of pd=0, then 16 samples of 2^21 -> stays TRACK through the first run, drops to ACQ (locked=0, shifts 8/3) after the 16th consecutive bad sample.
- Timeout and saturation: pd=-2^27 constant -> treated as bad; timeout and acc_clr each pulse once every 4096 updates; state stays 1.
- Freeze/disable: assert freeze for 40 clks mid-lock-count at good_cnt=30 -> no strobes; after release, lock at 34 further good samples. Then en=0 -> IDLE next cycle.
